// File: rtl/rc4_pkg.sv
// RC4 shared definitions: memory geometry, default key length and the
// KSA state encoding used by the shuffle FSM.
package rc4_pkg;

    localparam int RC4_N                  = 256;
    localparam int RC4_ADDR_W             = 8;
    localparam int RC4_DEFAULT_KEY_LENGTH = 3;

    localparam int ST_WREN_BIT = 13;
    localparam int ST_DONE_BIT = 12;

    // {wren, done, one-hot[11:0]}: output strobes come straight off the flops
    typedef enum logic [13:0] {
        IDLE = 14'b00_000000000001,
        RD_I = 14'b00_000000000010,
        WT_I = 14'b00_000000000100,
        LD_I = 14'b00_000000001000,
        RD_J = 14'b00_000000010000,
        WT_J = 14'b00_000000100000,
        LD_J = 14'b00_000001000000,
        WR_I = 14'b10_000010000000,
        WR_J = 14'b10_000100000000,
        WT_W = 14'b00_001000000000,
        NEXT = 14'b00_010000000000,
        DONE = 14'b01_100000000000
    } state_e;

    function automatic int key_idx_w(input int key_length);
        return (key_length > 1) ? $clog2(key_length) : 1;
    endfunction

endpackage

// File: rtl/ksa_shuffle_fsm_if.sv
// S-memory port bundle: the FSM is the master, the RAM is the slave.
interface ksa_shuffle_fsm_if;
    import rc4_pkg::*;

    logic [RC4_ADDR_W-1:0] address;
    logic [7:0]            data;
    logic                  wren;
    logic [7:0]            q;

    modport master (
        output address,
        output data,
        output wren,
        input  q
    );

    modport slave (
        input  address,
        input  data,
        input  wren,
        output q
    );

endinterface

// File: rtl/rc4_key_byte_select.sv
// Returns key byte k of secret_key; byte 0 is the most significant byte.
module rc4_key_byte_select
    import rc4_pkg::*;
#(
    parameter int KEY_LENGTH = RC4_DEFAULT_KEY_LENGTH,
    parameter int KW         = key_idx_w(KEY_LENGTH)
) (
    input  logic [8*KEY_LENGTH-1:0] secret_key,
    input  logic [KW-1:0]           k,
    output logic [7:0]              key_byte
);

    always_comb begin
        key_byte = '0;
        for (int n = 0; n < KEY_LENGTH; n++) begin
            if (k == KW'(n)) begin
                key_byte = secret_key[8*(KEY_LENGTH-n)-1 -: 8];
            end
        end
    end

endmodule

// File: rtl/ksa_shuffle_fsm.sv
// RC4 key-scheduling swap pass over the 256-byte S memory.
// Optional: define KSA_SKIP_SELF_SWAP_EN to skip iterations where j==i.
module ksa_shuffle_fsm
    import rc4_pkg::*;
#(
    parameter int KEY_LENGTH = RC4_DEFAULT_KEY_LENGTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [8*KEY_LENGTH-1:0] secret_key,
    input  logic [7:0]              q,
    output logic [7:0]              address,
    output logic [7:0]              data,
    output logic                    wren,
    output logic                    done
);

    localparam int KW = key_idx_w(KEY_LENGTH);
    localparam logic [KW-1:0] K_LAST = KW'(KEY_LENGTH - 1);

    state_e        state;
    state_e        state_nx;
    logic [7:0]    i;
    logic [7:0]    j;
    logic [7:0]    si;
    logic [7:0]    sj;
    logic [KW-1:0] k;
    logic [7:0]    key_byte;
    logic [7:0]    j_sum;

    rc4_key_byte_select #(
        .KEY_LENGTH (KEY_LENGTH),
        .KW         (KW)
    ) u_key_sel (
        .secret_key (secret_key),
        .k          (k),
        .key_byte   (key_byte)
    );

    assign j_sum = j + q + key_byte;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = start ? RD_I : IDLE;
            RD_I:    state_nx = WT_I;
            WT_I:    state_nx = LD_I;
`ifdef KSA_SKIP_SELF_SWAP_EN
            LD_I:    state_nx = (j_sum == i) ? NEXT : RD_J;
`else
            LD_I:    state_nx = RD_J;
`endif
            RD_J:    state_nx = WT_J;
            WT_J:    state_nx = LD_J;
            LD_J:    state_nx = WR_I;
            WR_I:    state_nx = WR_J;
            WR_J:    state_nx = WT_W;
            // settle cycle keeps a full iteration at ten cycles
            WT_W:    state_nx = NEXT;
            NEXT:    state_nx = (i == 8'hFF) ? DONE : RD_I;
            DONE:    state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            si    <= '0;
            sj    <= '0;
        end else begin
            state <= state_nx;
            if (state == LD_I) begin
                si <= q;
                j  <= j_sum;
            end
            if (state == LD_J) begin
                sj <= q;
            end
            if (state == NEXT && i != 8'hFF) begin
                i <= i + 8'd1;
                k <= (k == K_LAST) ? '0 : k + 1'b1;
            end
        end
    end

    assign wren = state[ST_WREN_BIT];
    assign done = state[ST_DONE_BIT];

    always_comb begin
        address = '0;
        data    = '0;
        unique case (state)
            RD_I, WT_I, LD_I:       address = i;
            RD_J, WT_J, LD_J, WT_W: address = j;
            WR_I: begin
                address = i;
                data    = sj;
            end
            WR_J: begin
                address = j;
                data    = si;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ksa_shuffle_fsm.sv
// Directed bench for ksa_shuffle_fsm with a behavioural single-port RAM
// and a software KSA reference for full-memory comparisons.
module tb_ksa_shuffle_fsm;
    import rc4_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [23:0] secret_key;
    logic        done;
    logic        mem_init;

    ksa_shuffle_fsm_if bus ();

    logic [7:0] mem [256];
    logic [7:0] raddr;
    logic [7:0] ref_s [256];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ksa_shuffle_fsm #(
        .KEY_LENGTH (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .secret_key (secret_key),
        .q          (bus.q),
        .address    (bus.address),
        .data       (bus.data),
        .wren       (bus.wren),
        .done       (done)
    );

    always @(posedge clk) begin
        if (mem_init) begin
            for (int n = 0; n < 256; n++) mem[n] <= 8'(n);
        end else if (bus.wren) begin
            mem[bus.address] <= bus.data;
        end
        raddr <= bus.address;
    end

    assign bus.q = mem[raddr];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic ksa_model(input logic [23:0] key);
        logic [7:0] jj;
        logic [7:0] t;
        int         kk;
        jj = 8'd0;
        kk = 0;
        for (int n = 0; n < 256; n++) ref_s[n] = 8'(n);
        for (int n = 0; n < 256; n++) begin
            jj = jj + ref_s[n] + key[8*(3-kk)-1 -: 8];
            t = ref_s[n];
            ref_s[n] = ref_s[jj];
            ref_s[jj] = t;
            kk = (kk == 2) ? 0 : kk + 1;
        end
    endtask

    task automatic cmp_mem(input string tag, input logic [23:0] key);
        ksa_model(key);
        for (int n = 0; n < 256; n++) begin
            chk($sformatf("%s[%0d]", tag, n), 32'(mem[n]), 32'(ref_s[n]));
        end
    endtask

    task automatic wait_write(input string tag, output logic [7:0] a,
                              output logic [7:0] d);
        a = '0;
        d = '0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.wren) break;
        end
        if (bus.wren) begin
            a = bus.address;
            d = bus.data;
        end else begin
            chk({tag, "_timeout"}, 32'(bus.wren), 32'd1);
        end
    endtask

    task automatic wait_done(input string tag, output int cyc);
        cyc = 0;
        for (int n = 1; n <= 5000; n++) begin
            @(negedge clk);
            cyc = n;
            if (done) break;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic load_identity(input logic [23:0] key);
        start      = 1'b0;
        secret_key = key;
        mem_init   = 1'b1;
        repeat (2) @(negedge clk);
        mem_init   = 1'b0;
    endtask

    initial begin
        int         hits;
        int         addr_nz;
        int         c;
        int         found;
        logic       prev;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] wa [6];
        logic [7:0] wd [6];
        int         n_exp;
        int         first_wr;

        reset      = 1'b1;
        start      = 1'b0;
        secret_key = '0;
        mem_init   = 1'b1;
        @(negedge clk);
        chk("rst_address", 32'(bus.address), 32'd0);
        chk("rst_data", 32'(bus.data), 32'd0);
        chk("rst_wren", 32'(bus.wren), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        reset    = 1'b0;
        mem_init = 1'b0;

        hits    = 0;
        addr_nz = 0;
        repeat (500) begin
            @(negedge clk);
            if (bus.wren) hits++;
            if (bus.address != 8'd0) addr_nz++;
        end
        chk("idle_wren_cnt", 32'(hits), 32'd0);
        chk("idle_addr_cnt", 32'(addr_nz), 32'd0);
        chk("idle_done", 32'(done), 32'd0);

        load_identity(24'hFF0000);
        start = 1'b1;
        wait_write("ff_wr_i", a, d);
        chk("ff_wr_i_addr", 32'(a), 32'h00);
        chk("ff_wr_i_data", 32'(d), 32'hFF);
        wait_write("ff_wr_j", a, d);
        chk("ff_wr_j_addr", 32'(a), 32'hFF);
        chk("ff_wr_j_data", 32'(d), 32'h00);
        start = 1'b0;

        found = 0;
        prev  = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (bus.wren && !prev && bus.address == 8'd100) begin
                found = 1;
                break;
            end
            prev = bus.wren;
        end
        chk("rst_i100_found", 32'(found), 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst_wren", 32'(bus.wren), 32'd0);
        chk("midrst_addr", 32'(bus.address), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_wren", 32'(bus.wren), 32'd0);
        chk("post_rst_addr", 32'(bus.address), 32'd0);

`ifdef KSA_SKIP_SELF_SWAP_EN
        n_exp    = 2;
        first_wr = 15;
        wa = '{8'd2, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0};
        wd = '{8'd3, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0};
`else
        n_exp    = 6;
        first_wr = 7;
        wa = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd3};
        wd = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd3, 8'd2};
`endif
        load_identity(24'h000000);
        start = 1'b1;
        c = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            c = n;
            if (bus.wren) break;
        end
        chk("k0_first_wr_cyc", 32'(c), 32'(first_wr));
        a = bus.address;
        d = bus.data;
        for (int w = 0; w < n_exp; w++) begin
            if (w > 0) wait_write($sformatf("k0_w%0d", w), a, d);
            chk($sformatf("k0_w%0d_addr", w), 32'(a), 32'(wa[w]));
            chk($sformatf("k0_w%0d_data", w), 32'(d), 32'(wd[w]));
        end
        wait_done("k0", c);
        cmp_mem("k0_mem", 24'h000000);

        hits = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.wren) hits++;
        end
        chk("done_hold", 32'(done), 32'd1);
        chk("done_no_wren", 32'(hits), 32'd0);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        load_identity(24'h000249);
        start = 1'b1;
        wait_done("k249", c);
`ifndef KSA_SKIP_SELF_SWAP_EN
        chk("k249_latency", 32'(c), 32'd2561);
`endif
        cmp_mem("k249_mem", 24'h000249);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
